// File: rtl/snn_spike_pkg.sv
// Shared constants for the spike address-event stream: field offsets, marker
// bytes and the encoder FSM encoding, plus a helper that packs one event word.
package snn_spike_pkg;

  localparam int X_LSB     = 0;
  localparam int Y_LSB     = 8;
  localparam int CH_LSB    = 16;
  localparam int VALID_LSB = 24;

  localparam logic [7:0] SPIKE_MARKER = 8'h01;
  localparam logic [7:0] EMPTY_MARKER = 8'h00;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_EMIT = 2'd1,
    ST_MARK = 2'd2
  } enc_state_e;

  function automatic logic [31:0] pack_event(input logic [7:0] marker,
                                             input logic [7:0] ch,
                                             input logic [7:0] y,
                                             input logic [7:0] x);
    logic [31:0] ev;
    ev                  = 32'd0;
    ev[VALID_LSB +: 8]  = marker;
    ev[CH_LSB +: 8]     = ch;
    ev[Y_LSB +: 8]      = y;
    ev[X_LSB +: 8]      = x;
    return ev;
  endfunction

endpackage

// File: rtl/snn_priority_encoder.sv
// Combinational lowest-set-bit finder: index, one-hot of that bit, and a flag
// telling whether it is the only bit set.
module snn_priority_encoder #(
  parameter int WIDTH = 28
) (
  input  logic [WIDTH-1:0] vec,
  output logic [7:0]       index,
  output logic [WIDTH-1:0] onehot,
  output logic             single
);

  localparam logic [WIDTH-1:0] ONE  = {{(WIDTH-1){1'b0}}, 1'b1};
  localparam logic [WIDTH-1:0] ZERO = {WIDTH{1'b0}};

  // Scan downward so the lowest set bit is the last one to win.
  always_comb begin
    index = 8'd0;
    for (int i = WIDTH - 1; i >= 0; i--) begin
      index = vec[i] ? 8'(i) : index;
    end
  end

  assign onehot = vec & (~vec + ONE);
  assign single = (vec != ZERO) && ((vec & (vec - ONE)) == ZERO);

endmodule

// File: rtl/snn_spike_encoder2d.sv
// Dense spike-row to address-event encoder: accepts one feature-map row per beat
// and emits one event per set bit, closing every timestep with a single tlast beat.
module snn_spike_encoder2d
  import snn_spike_pkg::*;
#(
  parameter int INPUT_WIDTH    = 28,
  parameter int INPUT_HEIGHT   = 28,
  parameter int INPUT_CHANNELS = 32
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [INPUT_WIDTH-1:0] s_axis_row_tdata,
  input  logic                   s_axis_row_tvalid,
  output logic                   s_axis_row_tready,
  input  logic                   s_axis_row_tlast,
  output logic [31:0]            m_axis_output_tdata,
  output logic                   m_axis_output_tvalid,
  input  logic                   m_axis_output_tready,
  output logic                   m_axis_output_tlast,
  output logic [31:0]            event_count,
  output logic                   timestep_done,
  output logic                   protocol_error
);

  localparam logic [7:0]             Y_LAST   = 8'(INPUT_HEIGHT - 1);
  localparam logic [7:0]             CH_LAST  = 8'(INPUT_CHANNELS - 1);
  localparam logic [INPUT_WIDTH-1:0] ROW_ZERO = {INPUT_WIDTH{1'b0}};

  enc_state_e             state_r, state_s;
  logic [INPUT_WIDTH-1:0] row_r, row_s;
  logic [7:0]             ch_r, ch_s, y_r, y_s, tag_ch_r, tag_ch_s, tag_y_r, tag_y_s;
  logic                   eot_r, eot_s;
  logic [31:0]            tdata_r, tdata_s, count_r, count_s;
  logic                   tvalid_r, tvalid_s, tlast_r, tlast_s;
  logic                   done_r, done_s, err_r, err_s;
  logic                   tready_s, accept_s, m_hs_s, pos_last_s, row_eot_s;
  logic [INPUT_WIDTH-1:0] pe_in_s, pe_onehot_s;
  logic [7:0]             pe_idx_s;
  logic                   pe_single_s;

  assign tready_s   = (state_r == ST_IDLE) && enable && !reset;
  assign accept_s   = s_axis_row_tvalid && tready_s;
  assign m_hs_s     = tvalid_r && m_axis_output_tready;
  assign pos_last_s = (ch_r == CH_LAST) && (y_r == Y_LAST);
  assign row_eot_s  = s_axis_row_tlast || pos_last_s;
  // row_r holds only the bits not yet presented, so one encoder serves both states.
  assign pe_in_s    = (state_r == ST_IDLE) ? s_axis_row_tdata : row_r;

  snn_priority_encoder #(.WIDTH(INPUT_WIDTH)) u_pe (
    .vec    (pe_in_s),
    .index  (pe_idx_s),
    .onehot (pe_onehot_s),
    .single (pe_single_s)
  );

  // Next-state, position counters and output-register values.
  always_comb begin
    state_s  = state_r;
    row_s    = row_r;
    ch_s     = ch_r;
    y_s      = y_r;
    tag_ch_s = tag_ch_r;
    tag_y_s  = tag_y_r;
    eot_s    = eot_r;
    tdata_s  = tdata_r;
    tvalid_s = tvalid_r;
    tlast_s  = tlast_r;
    count_s  = count_r;
    err_s    = err_r;
    done_s   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (accept_s) begin
          tag_ch_s = ch_r;
          tag_y_s  = y_r;
          eot_s    = row_eot_s;
          err_s    = err_r | (s_axis_row_tlast ^ pos_last_s);
          if (row_eot_s) begin
            ch_s = 8'd0;
            y_s  = 8'd0;
          end else if (y_r == Y_LAST) begin
            ch_s = ch_r + 8'd1;
            y_s  = 8'd0;
          end else begin
            y_s  = y_r + 8'd1;
          end
          if (s_axis_row_tdata != ROW_ZERO) begin
            state_s  = ST_EMIT;
            row_s    = s_axis_row_tdata & ~pe_onehot_s;
            tdata_s  = pack_event(SPIKE_MARKER, ch_r, y_r, pe_idx_s);
            tvalid_s = 1'b1;
            tlast_s  = row_eot_s && pe_single_s;
          end else if (row_eot_s) begin
            state_s  = ST_MARK;
            tdata_s  = pack_event(EMPTY_MARKER, ch_r, y_r, 8'h00);
            tvalid_s = 1'b1;
            tlast_s  = 1'b1;
          end else begin
            state_s  = ST_IDLE;
          end
        end else begin
          state_s = ST_IDLE;
        end
      end
      ST_EMIT: begin
        if (m_hs_s) begin
          count_s = count_r + 32'd1;
          done_s  = tlast_r;
          if (row_r != ROW_ZERO) begin
            row_s   = row_r & ~pe_onehot_s;
            tdata_s = pack_event(SPIKE_MARKER, tag_ch_r, tag_y_r, pe_idx_s);
            tlast_s = eot_r && pe_single_s;
          end else begin
            state_s  = ST_IDLE;
            tdata_s  = 32'd0;
            tvalid_s = 1'b0;
            tlast_s  = 1'b0;
          end
        end else begin
          state_s = ST_EMIT;
        end
      end
      ST_MARK: begin
        if (m_hs_s) begin
          done_s   = 1'b1;
          state_s  = ST_IDLE;
          tdata_s  = 32'd0;
          tvalid_s = 1'b0;
          tlast_s  = 1'b0;
        end else begin
          state_s = ST_MARK;
        end
      end
      default: begin
        state_s  = ST_IDLE;
        tdata_s  = 32'd0;
        tvalid_s = 1'b0;
        tlast_s  = 1'b0;
      end
    endcase
  end

  // State and output registers; reset discards any row in flight.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r  <= ST_IDLE;
      row_r    <= ROW_ZERO;
      ch_r     <= 8'd0;
      y_r      <= 8'd0;
      tag_ch_r <= 8'd0;
      tag_y_r  <= 8'd0;
      eot_r    <= 1'b0;
      tdata_r  <= 32'd0;
      tvalid_r <= 1'b0;
      tlast_r  <= 1'b0;
      count_r  <= 32'd0;
      err_r    <= 1'b0;
      done_r   <= 1'b0;
    end else begin
      state_r  <= state_s;
      row_r    <= row_s;
      ch_r     <= ch_s;
      y_r      <= y_s;
      tag_ch_r <= tag_ch_s;
      tag_y_r  <= tag_y_s;
      eot_r    <= eot_s;
      tdata_r  <= tdata_s;
      tvalid_r <= tvalid_s;
      tlast_r  <= tlast_s;
      count_r  <= count_s;
      err_r    <= err_s;
      done_r   <= done_s;
    end
  end

  assign s_axis_row_tready    = tready_s;
  assign m_axis_output_tdata  = tdata_r;
  assign m_axis_output_tvalid = tvalid_r;
  assign m_axis_output_tlast  = tlast_r;
  assign event_count          = count_r;
  assign timestep_done        = done_r;
  assign protocol_error       = err_r;

endmodule

// File: doc/snn_spike_encoder2d.md
# snn_spike_encoder2d

Converts dense per-timestep spike bitmaps (one row of a channel's feature map per input beat) into the sparse 32-bit address-event stream consumed by the SNN layer blocks (conv/pool/fc). It is the producer end of the spike-event AXI-Stream protocol. It sits between the input-frame DMA/spike generator and the first layer, and between any dense-output stage and the next event-driven layer.

## Interface
- INPUT_WIDTH, 28, bits per row (x range 0..INPUT_WIDTH-1, ≤256)
- INPUT_HEIGHT, 28, rows per channel (≤256)
- INPUT_CHANNELS, 32, channels per timestep (≤256)

- clk  in  1  clock
- reset  in  1  reset, synchronous, active-high
- enable  in  1  gates acceptance of new rows; in-flight emission always completes
- s_axis_row_tdata  in  INPUT_WIDTH  bit x = spike at (ch, y, x) for the current row
- s_axis_row_tvalid  in  1  row valid
- s_axis_row_tready  out  1  row accepted when tvalid&tready at a rising edge
- s_axis_row_tlast  in  1  last row of the timestep
- m_axis_output_tdata  out  32  [31:24] valid marker, [23:16] ch, [15:8] y, [7:0] x
- m_axis_output_tvalid  out  1  event valid
- m_axis_output_tready  in  1  downstream ready
- m_axis_output_tlast  out  1  final beat of the timestep
- event_count  out  32  spike events emitted (marker beats excluded), wraps
- timestep_done  out  1  one-cycle pulse on the handshake of the tlast beat
- protocol_error  out  1  sticky; set on row tlast / position mismatch

## Operation
- Row position counters (ch, y), raster order: y increments per accepted row; at y=INPUT_HEIGHT-1 wrap y→0, ch+1; end of timestep → ch=y=0.
- End of timestep = accepted row with s tlast=1 OR position (INPUT_CHANNELS-1, INPUT_HEIGHT-1). If only one of the two holds, set protocol_error; counters reset to 0 either way.
- FSM IDLE/EMIT/MARK.
  - IDLE: s_axis_row_tready = enable. On accept: non-zero row → register it, EMIT. Zero row at end of timestep with no events emitted this timestep → MARK. Other zero rows → stay IDLE, no output.
  - EMIT: present lowest set x as {8'h01, ch, y, x}; on m handshake clear that bit, next lowest set bit presented the next cycle. tlast=1 on the last remaining bit of an end-of-timestep row. After the final bit's handshake → IDLE.
  - MARK: present {8'h00, ch, y, 8'h00} with tlast=1 (downstream ignores valid byte 0). Handshake → IDLE.
- Zero end-of-timestep row when events were already emitted this timestep: MARK as well, so every timestep ends with exactly one tlast beat.
- AXI: m tdata/tvalid/tlast stable while tvalid=1 and tready=0. s_axis_row_tready=0 outside IDLE.
- event_count +1 per handshaked beat with marker 8'h01.

## Timing
- Reset values: s_axis_row_tready 0, m_axis_output_tvalid 0, m_axis_output_tdata 0, m_axis_output_tlast 0, event_count 0, timestep_done 0, protocol_error 0; FSM IDLE; ch=y=0.
- Row accepted at edge N → first event valid cycle N+1 (registered outputs).
- With m tready held high: row with k spikes occupies k+1 cycles (accept + k beats). Zero non-final rows occupy 1 cycle. MARK occupies 2 cycles.
- timestep_done is asserted the cycle after the tlast handshake.
- Reset mid-emission: row and beat are discarded, no partial tlast; the next timestep starts at ch=y=0.
- enable low during EMIT/MARK: emission continues; only the IDLE accept is blocked.

## Structure
- Shared package snn_spike_pkg: event field offsets (X_LSB=0, Y_LSB=8, CH_LSB=16, VALID_LSB=24), SPIKE_MARKER=8'h01, EMPTY_MARKER=8'h00, FSM state encoding. Layer blocks import the same constants.
- Sub-module snn_priority_encoder: INPUT_WIDTH-bit vector → lowest set index, one-hot of that bit, "exactly one bit set" flag. Purely combinational.
- Top module: FSM, row register, (ch, y) counters, output registers, status.

## Test plan
- Single row ch=0,y=0, bits {3,7}, tready=1 → beats 0x01000003, 0x01000007 on consecutive cycles, tlast=0; event_count=2.
- Full timestep with one spike at (ch=31,y=27,x=27) on the last row, s tlast on that row → single beat 0x011F1B1B with tlast=1; timestep_done pulses; protocol_error=0.
- All-zero timestep (896 zero rows, tlast on last) → exactly one beat 0x001F1B00 with tlast=1; event_count unchanged.
- Backpressure: row bits {0,1,2}, tready toggled 1010… → all three events delivered in order, each beat's tdata held stable while stalled.
- s tlast asserted on row 5 of ch 0 → protocol_error=1, the next row is tagged ch=0,y=0; MARK or tlast-on-final-event still issued.
- Reset asserted during EMIT of a 4-spike row after 2 beats → all outputs return to reset values the next cycle; the next row is tagged (0,0).
